// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES-256 key schedule controller.
// Holds the FSM state encoding, the round-key count and the Rcon table.
// No ports; imported by aes256_key_sched_ctrl.
package aes_pkg;

  localparam int NUM_RK = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_SUB  = 3'd2,
    ST_MIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Indexed by k/2 for even round-key index k (2..14); entry 0 is never used.
  localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box, one byte in, one byte out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports in_byte (8) -> out_byte (8).
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 sits in the top byte, so entry i starts at bit 8*(255-i) = {~i, 3'b000}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl: AES-256 key expansion into a 15x128 round-key store with a read port.
// Latency: RK[k] stored at end of cycle 6(k-1) after accept, all keys by cycle 79; reads answer next cycle.
// Backpressure: key_ready low while expanding; reads of not-yet-written keys stall with rk_valid low.
// Ports: clk, rst (sync, active high); key_in/key_valid/key_ready key load handshake;
//        rk_req/rk_idx read request; rk_out/rk_valid/rk_err read response; busy, keys_ready status.
module aes256_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         rk_err,
  output logic         busy,
  output logic         keys_ready
);

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       temp_q, temp_d;
  logic [127:0]      rk_q [NUM_RK];
  logic [127:0]      rk_d [NUM_RK];
  logic [NUM_RK-1:0] wr_q, wr_d;
  logic [127:0]      rk_out_q, rk_out_d;
  logic              rk_valid_q, rk_valid_d;
  logic              rk_err_q, rk_err_d;

  logic              key_acc;
  logic [3:0]        k_prev, k_base;
  logic [31:0]       prev_w, rcon_w, t_w;
  logic [31:0]       w0, w1, w2, w3;
  logic [127:0]      base_rk, new_rk;
  logic [7:0]        sbox_in, sbox_out;

  assign key_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy       = (state_q == ST_PREP) || (state_q == ST_SUB) || (state_q == ST_MIX);
  assign keys_ready = (state_q == ST_DONE);
  assign key_acc    = key_valid && key_ready;

  assign rk_out   = rk_out_q;
  assign rk_valid = rk_valid_q;
  assign rk_err   = rk_err_q;

  // temp is rotated left one byte per SUB cycle, so the byte to substitute is always on top.
  assign sbox_in = temp_q[31:24];

  aes_sbox u_sbox (
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  // k is below 2 only outside PREP/MIX; clamp so the store lookups stay in range.
  assign k_prev  = (k_q == 4'd0) ? 4'd0 : k_q - 4'd1;
  assign k_base  = (k_q < 4'd2)  ? 4'd0 : k_q - 4'd2;
  assign prev_w  = rk_q[k_prev][31:0];
  assign base_rk = rk_q[k_base];

  // Next round key from RK[k-2] and the substituted temp word.
  always_comb begin
    rcon_w = k_q[0] ? 32'h0 : {RCON[k_q[3:1]], 24'h0};
    t_w    = temp_q ^ rcon_w;
    w0     = base_rk[127:96] ^ t_w;
    w1     = base_rk[95:64]  ^ w0;
    w2     = base_rk[63:32]  ^ w1;
    w3     = base_rk[31:0]   ^ w2;
    new_rk = {w0, w1, w2, w3};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    wr_d    = wr_q;
    for (int i = 0; i < NUM_RK; i++) begin
      rk_d[i] = rk_q[i];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_acc) begin
          rk_d[0] = key_in[255:128];
          rk_d[1] = key_in[127:0];
          wr_d    = NUM_RK'(2'b11);
          k_d     = 4'd2;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        temp_d  = k_q[0] ? prev_w : {prev_w[23:0], prev_w[31:24]};
        cnt_d   = 2'd0;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        temp_d = {temp_q[23:0], sbox_out};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        rk_d[k_q] = new_rk;
        wr_d[k_q] = 1'b1;
        if (k_q == 4'd14) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = ST_PREP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reads look at the post-update store: a key written this cycle is served next cycle,
    // and a read that coincides with a restart only finds the freshly loaded RK0/RK1.
    rk_valid_d = 1'b0;
    rk_err_d   = 1'b0;
    rk_out_d   = '0;
    if (rk_req) begin
      if (rk_idx > 4'd14) begin
        rk_err_d = 1'b1;
      end else if (wr_d[rk_idx]) begin
        rk_valid_d = 1'b1;
        rk_out_d   = rk_d[rk_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      temp_q     <= '0;
      wr_q       <= '0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      temp_q     <= temp_d;
      wr_q       <= wr_d;
      rk_out_q   <= rk_out_d;
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// tb_aes256_key_sched_ctrl: self-checking bench for the AES-256 key schedule controller.
// Reference is a word-level FIPS-197 key expansion with an S-box derived from GF(2^8) math.
// Cycle 0 is the key accept cycle; outputs are sampled 1 time unit after each rising edge.
module tb_aes256_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         rk_err;
  logic         busy;
  logic         keys_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk_m   [15];
  logic [127:0] rd_cache [15];

  localparam logic [255:0] KEY_A =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_B =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes256_key_sched_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_err     (rk_err),
    .busy       (busy),
    .keys_ready (keys_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      end
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Plain FIPS-197 expansion over 60 words, then grouped into 15 round keys.
  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) rk_m[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Runs from cycle 1 of an expansion until the first rk_valid and keys_ready are seen.
  task automatic run_exp(input bit toggle, output int fv, output logic [127:0] fo, output int fkr);
    int cyc;
    cyc = 1;
    fv  = -1;
    fkr = -1;
    fo  = '0;
    while (cyc < 200 && (fv < 0 || fkr < 0)) begin
      if (rk_valid && fv < 0) begin
        fv = cyc;
        fo = rk_out;
      end
      if (keys_ready && fkr < 0) fkr = cyc;
      if (toggle && cyc < 79) begin
        key_valid = 1'($urandom_range(0, 1));
        key_in    = rand256();
      end else begin
        key_valid = 1'b0;
      end
      step();
      cyc++;
    end
    key_valid = 1'b0;
  endtask

  task automatic read_all(input string pfx);
    for (int i = 0; i < 15; i++) begin
      rk_req = 1'b1;
      rk_idx = 4'(i);
      step();
      chk($sformatf("%s_v%0d", pfx, i), rk_valid, 1'b1);
      chk($sformatf("%s_rk%0d", pfx, i), rk_out, rk_m[i]);
      rd_cache[i] = rk_out;
    end
    rk_req = 1'b0;
  endtask

  initial begin
    int           fv, fkr;
    logic [127:0] fo;
    logic         seen;

    build_sbox();
    rst = 1'b1; key_in = '0; key_valid = 1'b0; rk_req = 1'b0; rk_idx = '0;
    step();
    step();
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_keys_ready", keys_ready, 1'b0);
    chk("rst_rk_valid", rk_valid, 1'b0);
    chk("rst_rk_err", rk_err, 1'b0);
    chk("rst_rk_out", rk_out, 128'h0);
    rst = 1'b0;
    step();

    // FIPS-197 A.3 key, RK5 read held from cycle 1, key_valid noise while busy.
    expand(KEY_A);
    key_in = KEY_A; key_valid = 1'b1;
    step();
    key_valid = 1'b0; rk_req = 1'b1; rk_idx = 4'd5;
    chk("a_busy_c1", busy, 1'b1);
    chk("a_key_ready_c1", key_ready, 1'b0);
    run_exp(1'b1, fv, fo, fkr);
    chk("a_rk5_first_cycle", fv, 25);
    chk("a_rk5_val", fo, rk_m[5]);
    chk("a_keys_ready_cycle", fkr, 79);
    read_all("a");
    chk("a_rk2_fips", rd_cache[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a_rk14_fips", rd_cache[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Out-of-range index.
    rk_req = 1'b1; rk_idx = 4'd15;
    step();
    chk("err_flag", rk_err, 1'b1);
    chk("err_out", rk_out, 128'h0);
    chk("err_valid", rk_valid, 1'b0);
    rk_req = 1'b0;

    // Restart in DONE with a concurrent RK3 read: stale RK3 must not be served.
    expand(KEY_B);
    key_in = KEY_B; key_valid = 1'b1; rk_req = 1'b1; rk_idx = 4'd3;
    step();
    key_valid = 1'b0;
    chk("b_keys_ready_drop", keys_ready, 1'b0);
    chk("b_busy_c1", busy, 1'b1);
    chk("b_no_stale_rk3", rk_valid, 1'b0);
    run_exp(1'b0, fv, fo, fkr);
    chk("b_rk3_first_cycle", fv, 13);
    chk("b_rk3_val", fo, rk_m[3]);
    chk("b_keys_ready_cycle", fkr, 79);
    read_all("b");
    chk("b_rk14_vec", rd_cache[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Random key with a random read stream across the whole expansion.
    key_in = rand256();
    expand(key_in);
    key_valid = 1'b1;
    for (int c = 0; c < 86; c++) begin
      logic       rq, ev, ee;
      logic [3:0] ix;
      int         ii;
      rq = ($urandom_range(0, 3) != 0);
      ix = 4'($urandom_range(0, 15));
      ii = int'(ix);
      rk_req = rq; rk_idx = ix;
      step();
      key_valid = 1'b0;
      ee = rq && (ii > 14);
      ev = rq && (ii <= 14) && (ii <= 1 || c >= 6 * (ii - 1));
      chk($sformatf("r_v_c%0d", c), rk_valid, ev);
      chk($sformatf("r_e_c%0d", c), rk_err, ee);
      if (ev) chk($sformatf("r_rk_c%0d", c), rk_out, rk_m[ii]);
      if (ee) chk($sformatf("r_eo_c%0d", c), rk_out, 128'h0);
    end
    rk_req = 1'b0;

    // Reset at cycle 40 mid-expansion, then a full fresh expansion.
    key_in = rand256(); key_valid = 1'b1;
    step();
    key_valid = 1'b0; rk_req = 1'b1; rk_idx = 4'd14;
    seen = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (rk_valid) seen = 1'b1;
      step();
    end
    chk("e_no_rk14_before_rst", seen, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("e_rst_busy", busy, 1'b0);
    chk("e_rst_keys_ready", keys_ready, 1'b0);
    chk("e_rst_key_ready", key_ready, 1'b1);
    chk("e_rst_rk_valid", rk_valid, 1'b0);
    chk("e_rst_rk_out", rk_out, 128'h0);
    rk_idx = 4'd0;
    step();
    chk("e_no_stale_rk0", rk_valid, 1'b0);
    chk("e_no_stale_out", rk_out, 128'h0);
    key_in = rand256();
    expand(key_in);
    key_valid = 1'b1; rk_idx = 4'd14;
    step();
    key_valid = 1'b0;
    run_exp(1'b0, fv, fo, fkr);
    chk("e_rk14_first_cycle", fv, 79);
    chk("e_rk14_val", fo, rk_m[14]);
    chk("e_keys_ready_cycle", fkr, 79);
    read_all("e");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes256_key_sched_ctrl.md
AES256_KEY_SCHED_CTRL -- requirements
Module: aes256_key_sched_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 key_in  input  256  cipher key, FIPS-197 word order, key_in[255:224] = w[0].
REQ-003 key_valid  input  1  key offered; key_ready  output  1  key accepted when both are high.
REQ-004 rk_req  input  1  round-key read request; rk_idx  input  4  round index 0..14.
REQ-005 rk_out  output  128  round key, w[4k] in [127:96]; rk_valid  output  1  rk_out valid; rk_err  output  1  rk_idx > 14.
REQ-006 busy  output  1  expansion in progress; keys_ready  output  1  all 15 round keys stored.

Function
REQ-007 FSM states SHALL be IDLE, PREP, SUB, MIX and DONE.
REQ-008 key_ready SHALL be high in IDLE and DONE only.
REQ-009 On accept (cycle 0): RK0 = key_in[255:128] and RK1 = key_in[127:0] are written; keys_ready clears; next state is PREP with k = 2.
REQ-010 PREP (1 cycle) SHALL latch the last word of RK[k-1]: RotWord for even k, unrotated for odd k.
REQ-011 SUB (exactly 4 cycles) SHALL substitute one byte per cycle, MSB first, through a single shared S-box instance.
REQ-012 MIX (1 cycle) SHALL XOR Rcon[k/2] (01,02,04,08,10,20,40 for k = 2,4..14) into the top byte for even k only, then form w0 = RK[k-2].w0^temp and wj = RK[k-2].wj^w(j-1), and write RK[k].
REQ-013 After MIX, k SHALL increment and the FSM SHALL return to PREP; after k = 14 it goes to DONE.
REQ-014 Timing: RK[k] is written at the end of cycle 6(k-1); keys_ready and DONE are reached in cycle 79.
REQ-015 busy SHALL be high in PREP, SUB and MIX.
REQ-016 Read, idx <= 14 and RK[idx] written: rk_out = RK[idx] and rk_valid = 1 the next cycle.
REQ-017 Read, idx <= 14 and RK[idx] not yet written: rk_valid stays 0; the requester holds rk_req and rk_idx stable until rk_valid asserts.
REQ-018 Read, idx > 14: rk_err = 1 and rk_out = 0 the next cycle, with rk_valid = 0.
REQ-019 Reads SHALL be serviced in every state, one per cycle, with no bubbles.
REQ-020 A key_valid in DONE SHALL restart expansion; all keys are invalidated on the accept cycle.
REQ-021 If a read and a restart occur in the same cycle, the read SHALL be treated as against invalidated keys: only RK0/RK1 are served next cycle, and others stall.
REQ-022 key_valid while busy SHALL be ignored, with no state change.

Reset
REQ-023 rst SHALL force the FSM to IDLE, k = 0, and every output low/zero except key_ready = 1.
REQ-024 rst SHALL clear all written flags and zero the round-key store.
REQ-025 rst asserted mid-expansion SHALL abort the expansion; no partial key remains valid.

Structure
REQ-026 Package aes_pkg SHALL hold the FSM state enum, NUM_RK = 15, and the Rcon table.
REQ-027 The only sub-module SHALL be aes_sbox (8-bit in, 8-bit out, combinational), with exactly one instance.
REQ-028 Round keys SHALL be held in a 15x128 register array plus a 15-bit written-flag vector.

Verification
REQ-029 Key 603deb10..0914dff4 (FIPS-197 A.3) -> RK2 = 9ba35411 8e6925af a51a8b5f 2067fcde; RK14 = fe4890d1 e6188d0b 046df344 706c631e; keys_ready in cycle 79.
REQ-030 Key 000102..1f -> RK14 = 24fc79cc bf0979e9 371ac23c 6d68de36.
REQ-031 rk_req with idx = 5 held from cycle 1 -> rk_valid first high in cycle 25 with the correct RK5.
REQ-032 rk_idx = 15 -> rk_err = 1, rk_out = 0, rk_valid = 0 the next cycle.
REQ-033 rst pulsed at cycle 40, then a new key -> no stale key is served, and the full 79-cycle expansion repeats.
REQ-034 key_valid toggled while busy -> ignored; a new key in DONE restarts and keys_ready drops.
